multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main sequencing FSM for the multi-cycle RISC-V core. It fetches and decodes each instruction, then steps the shared ALU, memory port, PC and register file through the per-class cycle sequence. It drives the 4-bit `alu_option` code consumed by the ALU controller, and it evaluates branch outcomes from ALU flags.

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instruction[6:0]; valid from the instruction register from DECODE onward.
- `func_3_bits` in 3: instruction[14:12].
- `alu_zero` in 1: ALU result == 0.
- `alu_lsb` in 1: ALU result bit 0.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_valid` out 1: memory request active.
- `mem_write` out 1: the active request is a store.
- `addr_sel` out 1: 0 selects PC, 1 selects the ALU output register.
- `ir_write` out 1: latch the instruction register and old_pc.
- `pc_write` out 1: load the PC from the ALU result.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: write-back source; 00 alu_out, 01 mem data, 10 PC.
- `alu_src_a` out 2: ALU operand A; 00 rs1, 01 PC, 10 old_pc, 11 zero.
- `alu_src_b` out 2: ALU operand B; 00 rs2, 01 imm, 10 constant 4.
- `alu_option` out 4: instruction-class code to the ALU controller.
- `illegal` out 1: sticky unsupported-opcode flag.
- `state` out 3: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, BRANCH=5, TRAP=6.
- Outputs are combinational from `state`, `opcode` and `func_3_bits`. Every output not listed for a state is 0.
- Class codes driven on `alu_option`:
  - LOAD 0000011 -> 0000
  - OP-IMM 0010011 -> 0010
  - AUIPC 0010111 -> 0011
  - STORE 0100011 -> 0100
  - OP 0110011 -> 0110
  - LUI 0110111 -> 0111
  - BRANCH 1100011 -> 1100
  - JAL 1101111 and JALR 1100111 -> 1101
  - Any other opcode is illegal.
- FETCH:
  - Drives mem_valid=1, addr_sel=0.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, next state DECODE.
- DECODE:
  - Drives src_a=01, src_b=10, alu_option=0000, pc_write=1 (PC <= PC+4).
  - Illegal opcode -> TRAP; otherwise -> EXECUTE.
- EXECUTE, per class:
  - OP: a=00, b=00 -> WRITEBACK.
  - OP-IMM, LOAD, STORE: a=00, b=01. OP-IMM -> WRITEBACK; LOAD and STORE -> MEMORY.
  - LUI: a=11, b=01 -> WRITEBACK.
  - AUIPC: a=10, b=01 -> WRITEBACK.
  - BRANCH: a=00, b=00, code 1100. Latch taken into an internal flop, then -> BRANCH.
    - taken = alu_zero when f3=000.
    - taken = !alu_zero when f3=001.
    - taken = alu_lsb for any other f3.
  - JAL: a=10, b=01, pc_write=1, reg_write=1, wb_sel=10 -> FETCH. The PC register still holds old PC+4 during this cycle.
  - JALR: same as JAL but a=00. The datapath clears bit 0 of the target.
- MEMORY:
  - Drives mem_valid=1, addr_sel=1, and mem_write=1 for stores.
  - Holds while mem_ready=0.
  - On ready: STORE -> FETCH; LOAD -> WRITEBACK.
- WRITEBACK: reg_write=1; wb_sel=01 for LOAD, otherwise 00 -> FETCH.
- BRANCH: a=10, b=01, code 0011 (ADD), pc_write = taken flop -> FETCH.
- TRAP: illegal=1, all enables 0. TRAP is terminal until `rst`.

## Timing
- While `rst`=1 (sampled): on the next edge state=FETCH, taken=0, illegal=0.
- While `rst` is high, all outputs are forced to 0, including mem_valid.
- FETCH is driven from the first cycle after `rst` falls.
- Reset in any state, including mid-handshake in FETCH or MEMORY, aborts the operation. No write enable is asserted after the reset edge.
- mem_valid, mem_write and addr_sel stay constant while waiting for mem_ready. The transfer completes in the cycle where valid and ready are both high.
- Instruction latency with zero-wait memory (mem_ready tied 1):
  - OP, OP-IMM, LUI, AUIPC, STORE, BRANCH: 4 cycles.
  - LOAD: 5 cycles.
  - JAL, JALR: 3 cycles.
- Each wait cycle adds 1 cycle per memory access.
- The taken flop updates only at the end of EXECUTE for branches.

## Test plan
- ADD x3,x1,x2 with mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in cycle 4; alu_option=0110 in EXECUTE.
- LW with mem_ready low for 3 cycles in MEMORY -> MEMORY held 4 cycles, mem_valid stable, wb_sel=01 in WRITEBACK, total 8 cycles.
- BEQ, f3=000:
  - alu_zero=1 -> pc_write=1 in BRANCH.
  - alu_zero=0 -> pc_write=0 in BRANCH.
  - BNE with alu_zero=0 -> taken.
  - BLT with alu_lsb=1 -> taken.
- JAL -> 3 cycles; pc_write, reg_write and wb_sel=10 are all asserted together in EXECUTE.
- opcode 0000000 -> TRAP, illegal=1 sticky for 20 cycles; rst=1 -> next cycle state=0, illegal=0.
- rst asserted during a STORE in MEMORY with mem_ready=0 -> mem_valid=0 and mem_write=0 from the reset cycle; the next fetch begins after rst falls.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RISC-V core.
// Walks fetch/decode/execute/memory/writeback and resolves branches.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func_3_bits,
  input  logic       alu_zero,
  input  logic       alu_lsb,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_option,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_OPC  = 2'b10;
  localparam logic [1:0] A_ZERO = 2'b11;
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [3:0] CODE_ADD = 4'b0011;

  state_e state_q, state_d;
  logic   taken_q, taken_d;
  logic   illegal_q, illegal_d;

  logic       legal;
  logic [3:0] cls_code;
  logic       is_load, is_store;
  logic       br_taken;

  logic       mem_valid_c, mem_write_c, addr_sel_c;
  logic       ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] wb_sel_c, src_a_c, src_b_c;
  logic [3:0] alu_option_c;

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  always_comb begin
    legal    = 1'b1;
    cls_code = 4'b0000;
    case (opcode)
      OPC_LOAD:   cls_code = 4'b0000;
      OPC_OPIMM:  cls_code = 4'b0010;
      OPC_AUIPC:  cls_code = 4'b0011;
      OPC_STORE:  cls_code = 4'b0100;
      OPC_OP:     cls_code = 4'b0110;
      OPC_LUI:    cls_code = 4'b0111;
      OPC_BRANCH: cls_code = 4'b1100;
      OPC_JAL,
      OPC_JALR:   cls_code = 4'b1101;
      default:    legal    = 1'b0;
    endcase
  end

  // BEQ/BNE use the zero flag; all compare-style branches use the SLT(U) lsb
  always_comb begin
    case (func_3_bits)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = ~alu_zero;
      default: br_taken = alu_lsb;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    taken_d      = taken_q;
    illegal_d    = illegal_q;
    mem_valid_c  = 1'b0;
    mem_write_c  = 1'b0;
    addr_sel_c   = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    wb_sel_c     = WB_ALU;
    src_a_c      = A_RS1;
    src_b_c      = B_RS2;
    alu_option_c = 4'b0000;
    case (state_q)
      S_FETCH: begin
        mem_valid_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_c    = A_PC;
        src_b_c    = B_FOUR;
        pc_write_c = 1'b1;
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_option_c = cls_code;
        state_d      = S_WRITEBACK;
        case (opcode)
          OPC_OP: begin
            src_a_c = A_RS1;
            src_b_c = B_RS2;
          end
          OPC_OPIMM: begin
            src_a_c = A_RS1;
            src_b_c = B_IMM;
          end
          OPC_LOAD,
          OPC_STORE: begin
            src_a_c = A_RS1;
            src_b_c = B_IMM;
            state_d = S_MEMORY;
          end
          OPC_LUI: begin
            src_a_c = A_ZERO;
            src_b_c = B_IMM;
          end
          OPC_AUIPC: begin
            src_a_c = A_OPC;
            src_b_c = B_IMM;
          end
          OPC_BRANCH: begin
            src_a_c = A_RS1;
            src_b_c = B_RS2;
            taken_d = br_taken;
            state_d = S_BRANCH;
          end
          // PC already holds old_pc+4 here, so rd gets the link address
          OPC_JAL,
          OPC_JALR: begin
            src_a_c     = (opcode == OPC_JAL) ? A_OPC : A_RS1;
            src_b_c     = B_IMM;
            pc_write_c  = 1'b1;
            reg_write_c = 1'b1;
            wb_sel_c    = WB_PC;
            state_d     = S_FETCH;
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMORY: begin
        mem_valid_c = 1'b1;
        addr_sel_c  = 1'b1;
        mem_write_c = is_store;
        if (mem_ready) begin
          state_d = is_store ? S_FETCH : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        reg_write_c = 1'b1;
        wb_sel_c    = is_load ? WB_MEM : WB_ALU;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c      = A_OPC;
        src_b_c      = B_IMM;
        alu_option_c = CODE_ADD;
        pc_write_c   = taken_q;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // reset masks every output so an in-flight request is dropped at once
  assign mem_valid  = ~rst & mem_valid_c;
  assign mem_write  = ~rst & mem_write_c;
  assign addr_sel   = ~rst & addr_sel_c;
  assign ir_write   = ~rst & ir_write_c;
  assign pc_write   = ~rst & pc_write_c;
  assign reg_write  = ~rst & reg_write_c;
  assign wb_sel     = rst ? 2'b00 : wb_sel_c;
  assign alu_src_a  = rst ? 2'b00 : src_a_c;
  assign alu_src_b  = rst ? 2'b00 : src_b_c;
  assign alu_option = rst ? 4'b0000 : alu_option_c;
  assign illegal    = ~rst & illegal_q;
  assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Expected per-cycle output vectors go through a scoreboard queue.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func_3_bits;
  logic       alu_zero;
  logic       alu_lsb;
  logic       mem_ready;
  logic       mem_valid, mem_write, addr_sel;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] wb_sel, alu_src_a, alu_src_b;
  logic [3:0] alu_option;
  logic       illegal;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .func_3_bits(func_3_bits), .alu_zero(alu_zero),
    .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_write(mem_write),
    .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_option(alu_option),
    .illegal(illegal), .state(state)
  );

  // {state,mv,mw,as,irw,pcw,rw,wb,a,b,opt,ill}
  function automatic logic [19:0] E(
    input logic [2:0] st, input logic mv, input logic mw,
    input logic as_, input logic irw, input logic pcw,
    input logic rw, input logic [1:0] wb, input logic [1:0] a,
    input logic [1:0] b, input logic [3:0] opt, input logic ill);
    return {st, mv, mw, as_, irw, pcw, rw, wb, a, b, opt, ill};
  endfunction

  function automatic logic [19:0] fe(input logic irw);
    return E(3'd0, 1, 0, 0, irw, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0);
  endfunction
  function automatic logic [19:0] dc();
    return E(3'd1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 4'd0, 0);
  endfunction
  function automatic logic [19:0] ex(
    input logic [1:0] a, input logic [1:0] b, input logic [3:0] opt);
    return E(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, a, b, opt, 0);
  endfunction
  function automatic logic [19:0] exj(input logic [1:0] a);
    return E(3'd2, 0, 0, 0, 0, 1, 1, 2'd2, a, 2'd1, 4'b1101, 0);
  endfunction
  function automatic logic [19:0] mm(input logic mw);
    return E(3'd3, 1, mw, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0);
  endfunction
  function automatic logic [19:0] wbk(input logic [1:0] sel);
    return E(3'd4, 0, 0, 0, 0, 0, 1, sel, 2'd0, 2'd0, 4'd0, 0);
  endfunction
  function automatic logic [19:0] br(input logic t);
    return E(3'd5, 0, 0, 0, 0, t, 0, 2'd0, 2'd2, 2'd1, 4'b0011, 0);
  endfunction
  function automatic logic [19:0] tr();
    return E(3'd6, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 1);
  endfunction

  // push expectation for the current cycle, compare mid-cycle, advance
  task automatic step(input string tag, input logic [19:0] e);
    logic [19:0] got, exp_v;
    sb_q.push_back(e);
    @(negedge clk);
    got = {state, mem_valid, mem_write, addr_sel, ir_write,
           pc_write, reg_write, wb_sel, alu_src_a, alu_src_b,
           alu_option, illegal};
    exp_v = sb_q.pop_front();
    checks++;
    assert (got === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    func_3_bits = f3;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    alu_lsb = 1'b0;
    instr(7'b0110011, 3'b000);
    @(posedge clk);
    #1;
    step("rst_hold", 20'd0);
    rst = 1'b0;

    // ADD, zero wait: 0,1,2,4
    mem_ready = 1'b1;
    step("add_fetch", fe(1));
    step("add_decode", dc());
    step("add_exec", ex(2'd0, 2'd0, 4'b0110));
    step("add_wb", wbk(2'd0));

    // LW with 3 wait cycles in MEMORY
    instr(7'b0000011, 3'b010);
    step("lw_fetch", fe(1));
    step("lw_decode", dc());
    step("lw_exec", ex(2'd0, 2'd1, 4'b0000));
    mem_ready = 1'b0;
    step("lw_mem_w0", mm(0));
    step("lw_mem_w1", mm(0));
    step("lw_mem_w2", mm(0));
    mem_ready = 1'b1;
    step("lw_mem_done", mm(0));
    step("lw_wb", wbk(2'd1));

    // BEQ taken; flags flip during BRANCH must not matter
    instr(7'b1100011, 3'b000);
    alu_zero = 1'b1;
    step("beq_t_fetch", fe(1));
    step("beq_t_decode", dc());
    step("beq_t_exec", ex(2'd0, 2'd0, 4'b1100));
    alu_zero = 1'b0;
    step("beq_t_branch", br(1));

    step("beq_n_fetch", fe(1));
    step("beq_n_decode", dc());
    step("beq_n_exec", ex(2'd0, 2'd0, 4'b1100));
    alu_zero = 1'b1;
    step("beq_n_branch", br(0));

    instr(7'b1100011, 3'b001);
    step("bne_fetch", fe(1));
    alu_zero = 1'b0;
    step("bne_decode", dc());
    step("bne_exec", ex(2'd0, 2'd0, 4'b1100));
    step("bne_branch", br(1));

    instr(7'b1100011, 3'b100);
    alu_zero = 1'b1;
    alu_lsb = 1'b1;
    step("blt_fetch", fe(1));
    step("blt_decode", dc());
    step("blt_exec", ex(2'd0, 2'd0, 4'b1100));
    step("blt_branch", br(1));

    instr(7'b1100011, 3'b101);
    alu_lsb = 1'b0;
    alu_zero = 1'b0;
    step("bge_fetch", fe(1));
    step("bge_decode", dc());
    step("bge_exec", ex(2'd0, 2'd0, 4'b1100));
    step("bge_branch", br(0));

    // JAL and JALR: 3 cycles
    instr(7'b1101111, 3'b000);
    step("jal_fetch", fe(1));
    step("jal_decode", dc());
    step("jal_exec", exj(2'd2));
    instr(7'b1100111, 3'b000);
    step("jalr_fetch", fe(1));
    step("jalr_decode", dc());
    step("jalr_exec", exj(2'd0));

    // LUI with one fetch wait, AUIPC, OP-IMM
    instr(7'b0110111, 3'b000);
    mem_ready = 1'b0;
    step("lui_fetch_w", fe(0));
    mem_ready = 1'b1;
    step("lui_fetch", fe(1));
    step("lui_decode", dc());
    step("lui_exec", ex(2'd3, 2'd1, 4'b0111));
    step("lui_wb", wbk(2'd0));
    instr(7'b0010111, 3'b000);
    step("auipc_fetch", fe(1));
    step("auipc_decode", dc());
    step("auipc_exec", ex(2'd2, 2'd1, 4'b0011));
    step("auipc_wb", wbk(2'd0));
    instr(7'b0010011, 3'b000);
    step("opimm_fetch", fe(1));
    step("opimm_decode", dc());
    step("opimm_exec", ex(2'd0, 2'd1, 4'b0010));
    step("opimm_wb", wbk(2'd0));

    // STORE zero wait: 4 cycles
    instr(7'b0100011, 3'b010);
    step("sw_fetch", fe(1));
    step("sw_decode", dc());
    step("sw_exec", ex(2'd0, 2'd1, 4'b0100));
    step("sw_mem", mm(1));

    // illegal opcode -> sticky TRAP
    instr(7'b0000000, 3'b000);
    step("ill_fetch", fe(1));
    step("ill_decode", dc());
    for (int i = 0; i < 20; i++) begin
      step($sformatf("trap_%0d", i), tr());
    end
    rst = 1'b1;
    step("trap_rst", 20'd0);
    rst = 1'b0;
    instr(7'b0100011, 3'b010);
    step("post_trap_fetch", fe(1));

    // reset during a stalled STORE in MEMORY
    step("rs_decode", dc());
    step("rs_exec", ex(2'd0, 2'd1, 4'b0100));
    mem_ready = 1'b0;
    step("rs_mem", mm(1));
    rst = 1'b1;
    step("rs_rst", 20'd0);
    rst = 1'b0;
    step("rs_refetch", fe(0));
    mem_ready = 1'b1;
    step("rs_refetch_go", fe(1));
    step("rs_decode2", dc());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
